// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared scoreboard types (default register address/ID widths, sequencer state).
package reg_scoreboard_pkg;
  localparam int SB_NUM_REGS = 32;
  localparam int SB_ID_W = 3;
  typedef logic [$clog2(SB_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [SB_ID_W-1:0] sb_id_t;
  typedef enum logic {SB_CLEAR, SB_READY} sb_state_t;
endpackage

// File: rtl/reg_scoreboard_clear_seq.sv
// scoreboard_clear_seq: sweeps clr_idx over all entries after rst/flush; init_done high only in READY.
module scoreboard_clear_seq
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic [AW-1:0] clr_idx,
  output logic          init_done
);
  sb_state_t state_q;
  logic [AW-1:0] idx_q;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= SB_CLEAR;
      idx_q <= '0;
    end else if (state_q == SB_CLEAR) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == AW'(NUM_REGS - 1)) state_q <= SB_READY;
    end
  end
  assign clr_idx = idx_q;
  assign init_done = state_q == SB_READY;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-use bit and newest producer ID with multi-port lookup/retire.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ID_W = 3,
  parameter int NUM_RS = 2,
  parameter int NUM_RETIRE = 2,
  parameter int ZERO_REG_HARDWIRED = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  input  logic [ID_W-1:0]            issue_id,
  input  logic [NUM_RETIRE-1:0]      retire_valid,
  input  logic [NUM_RETIRE*AW-1:0]   retire_rd,
  input  logic [NUM_RETIRE*ID_W-1:0] retire_id,
  input  logic [NUM_RS*AW-1:0]       rs_addr,
  output logic [NUM_RS-1:0]          rs_inuse,
  output logic [NUM_RS*ID_W-1:0]     rs_id,
  output logic                       any_inuse,
  output logic                       init_done
);
  logic [NUM_REGS-1:0] inuse_q, iss_hit, ret_hit;
  logic [ID_W-1:0] owner_q [NUM_REGS];
  logic [AW-1:0] clr_idx;
  logic ready;
  scoreboard_clear_seq #(.NUM_REGS(NUM_REGS)) u_seq (
    .clk(clk), .rst(rst), .flush(flush), .clr_idx(clr_idx), .init_done(ready)
  );
  assign init_done = ready;
  always_comb begin
    iss_hit = '0;
    ret_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      iss_hit[r] = issue_valid && issue_rd == AW'(r) && !(ZERO_REG_HARDWIRED != 0 && r == 0);
      for (int p = 0; p < NUM_RETIRE; p++)
        ret_hit[r] = ret_hit[r] || (retire_valid[p] && retire_rd[p*AW +: AW] == AW'(r)
                     && owner_q[r] == retire_id[p*ID_W +: ID_W]);
    end
  end
  // Issue takes priority over a same-cycle matching retire to the same entry.
  always_ff @(posedge clk) begin
    if (!ready) begin
      inuse_q[clr_idx] <= 1'b0;
      owner_q[clr_idx] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (iss_hit[r]) begin
          inuse_q[r] <= 1'b1;
          owner_q[r] <= issue_id;
        end else if (ret_hit[r]) inuse_q[r] <= 1'b0;
    end
  end
  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    logic [AW-1:0] a;
    logic z;
    assign a = rs_addr[i*AW +: AW];
    assign z = ZERO_REG_HARDWIRED != 0 && a == '0;
    assign rs_inuse[i] = !ready || (inuse_q[a] && !z);
    assign rs_id[i*ID_W +: ID_W] = (ready && !z) ? owner_q[a] : '0;
  end
  assign any_inuse = !ready || |inuse_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: vector table with an expected-result queue for reg_scoreboard.
module tb_reg_scoreboard;
  logic clk = 0, rst = 1, flush = 0, issue_valid = 0;
  logic [4:0] issue_rd = 0;
  logic [2:0] issue_id = 0;
  logic [1:0] retire_valid = 0;
  logic [9:0] retire_rd = 0;
  logic [5:0] retire_id = 0;
  logic [9:0] rs_addr = 0;
  logic [1:0] rs_inuse;
  logic [5:0] rs_id;
  logic any_inuse, init_done;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic fl, iv;
    logic [4:0] ird;
    logic [2:0] iid;
    logic [1:0] rv;
    logic [4:0] rrd0;
    logic [2:0] rid0;
    logic [4:0] rrd1;
    logic [2:0] rid1;
    logic [4:0] ra0, ra1;
    logic [1:0] eu;
    logic [2:0] e0, e1;
    logic ea, ed;
  } vec_t;
  vec_t tbl[$];
  vec_t q[$];
  reg_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_id(issue_id), .retire_valid(retire_valid), .retire_rd(retire_rd),
    .retire_id(retire_id), .rs_addr(rs_addr), .rs_inuse(rs_inuse), .rs_id(rs_id),
    .any_inuse(any_inuse), .init_done(init_done)
  );
  always #5 clk = ~clk;
  function automatic vec_t V(logic fl, logic iv, logic [4:0] ird, logic [2:0] iid, logic [1:0] rv,
                             logic [4:0] rrd0, logic [2:0] rid0, logic [4:0] rrd1, logic [2:0] rid1,
                             logic [4:0] ra0, logic [4:0] ra1, logic [1:0] eu, logic [2:0] e0,
                             logic [2:0] e1, logic ea, logic ed);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ird = ird; v.iid = iid; v.rv = rv;
    v.rrd0 = rrd0; v.rid0 = rid0; v.rrd1 = rrd1; v.rid1 = rid1;
    v.ra0 = ra0; v.ra1 = ra1; v.eu = eu; v.e0 = e0; v.e1 = e1; v.ea = ea; v.ed = ed;
    return v;
  endfunction
  function automatic vec_t NR(logic [4:0] ra0, logic [4:0] ra1);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1, 2'b11, 0, 0, 1, 0);
  endfunction
  task automatic drive(input vec_t v);
    flush = v.fl; issue_valid = v.iv; issue_rd = v.ird; issue_id = v.iid;
    retire_valid = v.rv; retire_rd = {v.rrd1, v.rrd0}; retire_id = {v.rid1, v.rid0};
    rs_addr = {v.ra1, v.ra0};
    q.push_back(v);
  endtask
  task automatic check();
    vec_t e;
    e = q.pop_front();
    n_vec++;
    if (rs_inuse !== e.eu || rs_id !== {e.e1, e.e0} || any_inuse !== e.ea || init_done !== e.ed) begin
      n_bad++;
      $display("FAIL vec %0d: got inuse=%b id=%h any=%b done=%b, want inuse=%b id=%h any=%b done=%b",
               n_vec, rs_inuse, rs_id, any_inuse, init_done, e.eu, {e.e1, e.e0}, e.ea, e.ed);
    end
  endtask
  task automatic apply(input vec_t v);
    drive(v);
    @(posedge clk);
    #1 check();
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 31; i++) tbl.push_back(NR(5, 9));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 2'b00, 0, 0, 0, 1));
    tbl.push_back(V(0, 1, 5, 3, 0, 0, 0, 0, 0, 5, 7, 2'b01, 3, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b10, 0, 0, 5, 3, 5, 7, 2'b00, 3, 0, 0, 1));
    tbl.push_back(V(0, 1, 7, 1, 0, 0, 0, 0, 0, 7, 0, 2'b01, 1, 0, 1, 1));
    tbl.push_back(V(0, 1, 7, 2, 0, 0, 0, 0, 0, 7, 0, 2'b01, 2, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b01, 7, 1, 0, 0, 7, 0, 2'b01, 2, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b01, 7, 2, 0, 0, 7, 0, 2'b00, 2, 0, 0, 1));
    tbl.push_back(V(0, 1, 9, 4, 0, 0, 0, 0, 0, 9, 0, 2'b01, 4, 0, 1, 1));
    tbl.push_back(V(0, 1, 9, 6, 2'b01, 9, 4, 0, 0, 9, 0, 2'b01, 6, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b10, 0, 0, 9, 6, 9, 0, 2'b00, 6, 0, 0, 1));
    tbl.push_back(V(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    tbl.push_back(V(0, 1, 12, 2, 0, 0, 0, 0, 0, 0, 12, 2'b10, 0, 2, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b11, 12, 5, 12, 2, 0, 12, 2'b00, 0, 2, 0, 1));
    tbl.push_back(V(0, 1, 3, 1, 0, 0, 0, 0, 0, 3, 4, 2'b01, 1, 0, 1, 1));
    tbl.push_back(V(0, 1, 4, 2, 0, 0, 0, 0, 0, 3, 4, 2'b11, 1, 2, 1, 1));
    tbl.push_back(V(0, 1, 8, 5, 0, 0, 0, 0, 0, 8, 4, 2'b11, 5, 2, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 2'b11, 8, 5, 4, 7, 8, 4, 2'b10, 5, 2, 1, 1));
    tbl.push_back(V(0, 1, 8, 3, 0, 0, 0, 0, 0, 3, 8, 2'b11, 1, 3, 1, 1));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 2'b11, 0, 0, 1, 0));
    for (int i = 0; i < 29; i++) tbl.push_back(NR(3, 4));
    for (int i = 0; i < 2; i++) tbl.push_back(V(0, 1, 3, 7, 2'b01, 3, 0, 0, 0, 3, 4, 2'b11, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 2'b00, 0, 0, 0, 1));
    for (int r = 0; r < 32; r += 2)
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r + 1), 2'b00, 0, 0, 0, 1));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 0, 0, 1, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(NR(1, 2));
    tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b11, 0, 0, 1, 0));
    for (int i = 0; i < 31; i++) tbl.push_back(NR(1, 2));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2'b00, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    drive(NR(5, 9));
    #1 check();
    foreach (tbl[i]) apply(tbl[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register scoreboard for the issue stage; successor to the single-issue in-use tracker.
- Tracks, per architectural register, an in-use bit and the ID of its newest producer.
- Supports multiple source-lookup ports and multiple retire ports, ignores stale retirements, and hardwires register 0 as never in use.
- Has a built-in clear sequencer for post-reset init and pipeline flush. Sits between decode/issue and the writeback/retire ports.

Parameters:
- NUM_REGS, 32, number of tracked registers; power of two, ≥ 4.
- ID_W, 3, width of the producer ID tag.
- NUM_RS, 2, number of source lookup ports.
- NUM_RETIRE, 2, number of retire ports.
- ZERO_REG_HARDWIRED, 1, when 1 register 0 never reads in use and its issues are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- flush  in  1  request full clear of all entries.
- issue_valid  in  1  instruction with destination issued this cycle.
- issue_rd  in  log2(NUM_REGS)  destination register.
- issue_id  in  ID_W  producer ID.
- retire_valid  in  NUM_RETIRE  per-port retire strobe.
- retire_rd  in  NUM_RETIRE x log2(NUM_REGS)  retiring destination.
- retire_id  in  NUM_RETIRE x ID_W  retiring producer ID.
- rs_addr  in  NUM_RS x log2(NUM_REGS)  source lookup addresses.
- rs_inuse  out  NUM_RS  source has a pending producer.
- rs_id  out  NUM_RS x ID_W  owner ID of the looked-up entry.
- any_inuse  out  1  OR of all in-use bits (fence/drain).
- init_done  out  1  scoreboard valid, issue permitted.

Behaviour:
- Storage per entry: inuse (1 bit) and owner (ID_W bits). Storage is not reset directly; it is cleared by the sequencer.
- States:
  - CLEAR: counter clr_idx steps 0..NUM_REGS-1, clearing entry clr_idx (inuse=0, owner=0) each cycle. At clr_idx==NUM_REGS-1 it moves to READY next edge. The counter wraps to 0.
  - READY: normal operation.
- Transitions:
  - rst → CLEAR, clr_idx=0.
  - flush in READY → CLEAR, clr_idx=0.
  - flush in CLEAR restarts clr_idx at 0.
  - rst mid-sweep restarts identically.
- init_done is 1 only in READY. It rises exactly NUM_REGS cycles after rst deasserts, given no flush.
- Outputs while not READY:
  - rs_inuse all 1, any_inuse=1, rs_id=0. The reset value of all outputs follows from this.
  - issue_valid and retire_valid are ignored in CLEAR.
- Issue (READY): on issue_valid the entry at issue_rd becomes inuse=1, owner=issue_id at the next edge.
  - Re-issue to an already-busy rd overwrites owner.
  - With ZERO_REG_HARDWIRED, issue_rd==0 is dropped.
- Retire (READY): for each port p with retire_valid[p], if owner[retire_rd[p]]==retire_id[p], clear inuse. A mismatch means a stale producer; the entry is unchanged.
- Simultaneous events:
  - Issue and a matching retire to the same rd in one cycle: issue wins (inuse=1, owner=issue_id).
  - Two retire ports on the same rd: the entry clears if either matches.
  - Retires to different rds are applied independently.
- Lookup: rs_inuse and rs_id are combinational reads of the registered state. Updates are visible the cycle after the issue/retire edge; there is no same-cycle bypass.
  - With ZERO_REG_HARDWIRED, address 0 reads inuse=0, id=0.
- any_inuse: combinational OR across entries, or 1 when not READY.

Decomposition:
- Package taiga_types additions: reg_addr_t (log2(NUM_REGS) bits), sb_id_t (ID_W bits), enum sb_state_t {SB_CLEAR, SB_READY}.
- Sub-module scoreboard_clear_seq: owns the state register, clr_idx counter, flush/rst restart logic, and init_done.
- The main module keeps the entry arrays, issue/retire write logic, and lookup muxes.

Test Plan:
- Reset then idle: rst for 2 cycles, release → init_done=0 for exactly 32 cycles and rs_inuse=2'b11 during them; cycle 33 init_done=1, rs_inuse=0, any_inuse=0.
- Issue and retire:
  - Issue rd=5 id=3 → next cycle rs_addr[0]=5 gives rs_inuse[0]=1, rs_id[0]=3.
  - Retire rd=5 id=3 on port 1 → following cycle rs_inuse[0]=0.
- Stale retire: issue rd=7 id=1, then issue rd=7 id=2, then retire rd=7 id=1 → rd 7 stays inuse, owner=2. Retire id=2 → clears.
- Same-cycle collision: rd=9 busy id=4; in one cycle retire rd=9 id=4 and issue rd=9 id=6 → rd 9 inuse=1, owner=6.
- Zero register and dual retire:
  - Issue rd=0 → rs_addr=0 reads inuse=0.
  - rd=12 busy id=2; port0 retires rd=12 id=5 and port1 retires rd=12 id=2 in the same cycle → rd=12 clears.
- Flush mid-operation: busy rds 3, 4, 8; assert flush → init_done=0 next cycle for 32 cycles, issues ignored. After READY all entries read 0. A second flush at clr_idx=10 restarts the count, giving 32 further cycles.
